// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer with manual select and prescaled auto-scan.
// Optional per-channel scan masking is enabled by defining MUX_SCAN_MASK_EN.
module mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int TICK_DIV = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       mask,
`endif
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t              state, next_state;
  logic [PW-1:0]       presc, next_presc;
  logic [SEL_W-1:0]    next_chan, adv_chan;
  logic                next_tick, adv_found;
  logic [CHANNELS-1:0] en;
  logic [WIDTH-1:0]    sel_data;
  int                  idx;

`ifdef MUX_SCAN_MASK_EN
  assign en = mask;
`else
  assign en = '1;
`endif

  // Next enabled channel cyclically after chan_out; the descending loop leaves the nearest one.
  always_comb begin
    adv_chan  = chan_out;
    adv_found = 1'b0;
    idx       = 0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = (int'(chan_out) + i) % CHANNELS;
      if (en[idx]) begin
        adv_chan  = SEL_W'(idx);
        adv_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    next_chan  = chan_out;
    next_presc = '0;
    next_tick  = 1'b0;
    if (!mode) begin
      next_state = MANUAL;
      if (int'(sel) < CHANNELS) next_chan = sel;
    end else if (state == MANUAL) begin
      next_state = SCAN;
    end else if (presc == TERM) begin
      next_chan = adv_chan;
      next_tick = adv_found;
    end else begin
      next_presc = presc + 1'b1;
    end
  end

  assign sel_data = data_in[int'(next_chan)*WIDTH +: WIDTH];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= MANUAL;
      presc    <= '0;
      chan_out <= '0;
      data_out <= '0;
      tick     <= 1'b0;
    end else if (hold) begin
      tick <= 1'b0;
    end else begin
      state    <= next_state;
      presc    <= next_presc;
      chan_out <= next_chan;
      data_out <= sel_data;
      tick     <= next_tick;
    end
  end

endmodule
